// File: rtl/perceptron_pkg.sv
// Shared field layout for the perceptron configuration word (pack and slice sides).
// PACKER_PARITY_EN: when defined, word[0] carries even parity over the full word.
`default_nettype none

package perceptron_pkg;

  localparam int A_W     = 4;
  localparam int B_W     = 6;
  localparam int WORD_W  = 16;

  localparam int A_LSB   = 8;
  localparam int A_MSB   = 11;
  localparam int B_LSB   = 1;
  localparam int B_MSB   = 6;
  localparam int TAG_LSB = 12;
  localparam int TAG_MSB = 15;
  localparam int PAR_BIT = 0;

  localparam logic [3:0] TAG_DEFAULT = 4'b0001;

  // Capture state is the flag pair {a_full, b_full}
  localparam logic [1:0] CAP_EMPTY  = 2'b00;
  localparam logic [1:0] CAP_HAVE_A = 2'b10;
  localparam logic [1:0] CAP_HAVE_B = 2'b01;
  localparam logic [1:0] CAP_PAIRED = 2'b11;

  typedef struct packed {
    logic [3:0]     tag;
    logic [A_W-1:0] a;
    logic           pad;
    logic [B_W-1:0] b;
    logic           parity;
  } pw_word_t;

  function automatic logic [WORD_W-1:0] pack_fields(input logic [A_W-1:0] a,
                                                    input logic [B_W-1:0] b);
    logic [WORD_W-1:0] w;
    w                  = '0;
    w[TAG_MSB:TAG_LSB] = TAG_DEFAULT;
    w[A_MSB:A_LSB]     = a;
    w[B_MSB:B_LSB]     = b;
`ifdef PACKER_PARITY_EN
    w[PAR_BIT]         = ^w[WORD_W-1:PAR_BIT+1];
`endif
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pack_fifo2.sv
// Two-entry synchronous FIFO; push when full and pop when empty are ignored.
`default_nettype none

module pack_fifo2 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [1:0]       o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

`default_nettype wire

// File: rtl/perceptron_word_packer.sv
// Joins independently arriving A/B fields into tagged 16-bit words behind a 2-deep FIFO.
// PACKER_PARITY_EN: when defined, word[0] carries even parity over the full word.
`default_nettype none

module perceptron_word_packer
  import perceptron_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_a_valid,
  output logic              in_a_ready,
  input  logic [A_W-1:0]    in_a_data,
  input  logic              in_b_valid,
  output logic              in_b_ready,
  input  logic [B_W-1:0]    in_b_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic [7:0]        word_cnt
);

  logic [1:0]        r_cap;
  logic [A_W-1:0]    r_a_hold;
  logic [B_W-1:0]    r_b_hold;
  logic [7:0]        r_word_cnt;

  logic [1:0]        w_cap_next;
  logic              w_pack_fire;
  logic              w_a_take;
  logic              w_b_take;
  logic [1:0]        w_fifo_cnt;
  logic              w_fifo_empty;
  logic              w_unused_full;
  pw_word_t          w_word;

  // Registered FIFO count: a pop in this cycle cannot make room for this cycle's push
  assign w_pack_fire = (r_cap == CAP_PAIRED) && (w_fifo_cnt != 2'd2);
  assign in_a_ready  = !r_cap[1] || w_pack_fire;
  assign in_b_ready  = !r_cap[0] || w_pack_fire;
  assign w_a_take    = in_a_valid && in_a_ready;
  assign w_b_take    = in_b_valid && in_b_ready;
  assign w_word      = pw_word_t'(pack_fields(r_a_hold, r_b_hold));

  always_comb begin
    w_cap_next    = r_cap;
    w_cap_next[1] = w_a_take || (r_cap[1] && !w_pack_fire);
    w_cap_next[0] = w_b_take || (r_cap[0] && !w_pack_fire);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cap      <= CAP_EMPTY;
      r_a_hold   <= '0;
      r_b_hold   <= '0;
      r_word_cnt <= 8'd0;
    end else begin
      r_cap <= w_cap_next;
      if (w_a_take) r_a_hold <= in_a_data;
      if (w_b_take) r_b_hold <= in_b_data;
      if (w_pack_fire) r_word_cnt <= r_word_cnt + 8'd1;
    end
  end

  pack_fifo2 #(
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_pack_fire),
    .i_din   (w_word),
    .i_pop   (out_valid && out_ready),
    .o_head  (out_word),
    .o_count (w_fifo_cnt),
    .o_full  (w_unused_full),
    .o_empty (w_fifo_empty)
  );

  assign out_valid = !w_fifo_empty;
  assign word_cnt  = r_word_cnt;

endmodule

`default_nettype wire

// File: tb/tb_perceptron_word_packer.sv
// Directed self-checking bench for perceptron_word_packer.
`default_nettype none

module tb_perceptron_word_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_a_valid = 1'b0;
  logic        in_a_ready;
  logic [3:0]  in_a_data = '0;
  logic        in_b_valid = 1'b0;
  logic        in_b_ready;
  logic [5:0]  in_b_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_word;
  logic [7:0]  word_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] exp_q[$];

  perceptron_word_packer dut (
    .clk        (clk),
    .rst        (rst),
    .in_a_valid (in_a_valid),
    .in_a_ready (in_a_ready),
    .in_a_data  (in_a_data),
    .in_b_valid (in_b_valid),
    .in_b_ready (in_b_ready),
    .in_b_data  (in_b_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_word   (out_word),
    .word_cnt   (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] exp_word(input logic [3:0] a, input logic [5:0] b);
    logic [15:0] w;
    w = {4'b0001, a, 1'b0, b, 1'b0};
`ifdef PACKER_PARITY_EN
    w[0] = ^w[15:1];
`endif
    return w;
  endfunction

  // Called at a negedge; returns at the negedge after the last requested field is taken
  task automatic offer(input bit da, input logic [3:0] a, input bit db, input logic [5:0] b);
    bit pa, pb, ta, tb;
    int guard;
    pa = da; pb = db; guard = 0;
    in_a_valid = da; in_a_data = a;
    in_b_valid = db; in_b_data = b;
    while ((pa || pb) && guard < 50) begin
      ta = pa && in_a_ready;
      tb = pb && in_b_ready;
      @(posedge clk); @(negedge clk);
      if (ta) begin pa = 0; in_a_valid = 0; end
      if (tb) begin pb = 0; in_b_valid = 0; end
      guard++;
    end
    if (pa || pb) check("offer_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [15:0] w1, p1, p2, p3;
    int received, gaps, guard, i;
    bit acc;

    do_reset();
    check("rst_a_ready", in_a_ready, 1);
    check("rst_b_ready", in_b_ready, 1);
    check("rst_valid",   out_valid,  0);
    check("rst_word",    out_word,   16'h0000);
    check("rst_cnt",     word_cnt,   0);

    // Both fields in one cycle: word visible two edges after acceptance
    offer(1, 4'b1010, 1, 6'b010010);
    check("lat_edge1", out_valid, 0);
    @(negedge clk);
    check("lat_edge2", out_valid, 1);
`ifdef PACKER_PARITY_EN
    w1 = 16'h1A25;
`else
    w1 = 16'h1A24;
`endif
    check("pair_word", out_word, w1);
    check("pair_cnt",  word_cnt, 1);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check("pop_empty", out_valid, 0);

    // B early, A withheld for 5 cycles
    offer(0, 4'b0, 1, 6'b111111);
    for (int k = 0; k < 5; k++) begin
      check("bhold_ready", in_b_ready, 0);
      check("bhold_valid", out_valid,  0);
      @(negedge clk);
    end
    offer(1, 4'b0111, 0, 6'b0);
    @(negedge clk);
    check("late_a_valid", out_valid, 1);
    check("late_a_field", out_word[11:1], 11'b0111_0_111111);
    check("late_a_word",  out_word, exp_word(4'b0111, 6'b111111));
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;

    // Backpressure: two words fill the FIFO, third pair waits in the holding registers
    p1 = exp_word(4'b0011, 6'b000101);
    p2 = exp_word(4'b1111, 6'b100000);
    p3 = exp_word(4'b1000, 6'b011110);
    offer(1, 4'b0011, 1, 6'b000101);
    offer(1, 4'b1111, 1, 6'b100000);
    offer(1, 4'b1000, 1, 6'b011110);
    check("bp_valid",   out_valid,  1);
    check("bp_a_ready", in_a_ready, 0);
    check("bp_b_ready", in_b_ready, 0);
    check("bp_head1",   out_word,   p1);
    @(negedge clk);
    check("bp_stable",  out_word,   p1);
    check("bp_cnt",     word_cnt,   4);
    out_ready = 1;
    @(negedge clk);
    check("bp_head2",   out_word,   p2);
    check("bp_ready2",  in_a_ready, 1);
    @(negedge clk);
    check("bp_head3",   out_word,   p3);
    check("bp_cnt3",    word_cnt,   5);
    @(negedge clk);
    check("bp_drained", out_valid,  0);
    out_ready = 0;

    // Reset with a word queued and A held
    offer(1, 4'b0101, 1, 6'b101010);
    @(negedge clk);
    offer(1, 4'b1100, 0, 6'b0);
    check("mid_valid", out_valid, 1);
    rst = 1'b0;
    #1;
    check("async_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    check("mr_a_ready", in_a_ready, 1);
    check("mr_b_ready", in_b_ready, 1);
    check("mr_word",    out_word,   16'h0000);
    check("mr_cnt",     word_cnt,   0);
    offer(0, 4'b0, 1, 6'b000011);
    for (int k = 0; k < 3; k++) begin
      check("mr_no_stale", out_valid, 0);
      check("mr_b_held",   in_b_ready, 0);
      @(negedge clk);
    end
    offer(1, 4'b0010, 0, 6'b0);
    @(negedge clk);
    check("mr_word2", out_word, exp_word(4'b0010, 6'b000011));
    check("mr_cnt2",  word_cnt, 1);

    // Streaming 300 pairs from a clean reset
    do_reset();
    out_ready = 1;
    received = 0;
    gaps = 0;
    fork
      begin
        i = 0;
        in_a_valid = 1; in_b_valid = 1;
        in_a_data = 4'(i); in_b_data = 6'(i * 7);
        guard = 0;
        while (i < 300 && guard < 2000) begin
          acc = in_a_ready && in_b_ready;
          @(posedge clk); @(negedge clk);
          if (acc) begin
            exp_q.push_back(exp_word(in_a_data, in_b_data));
            i++;
            in_a_data = 4'(i); in_b_data = 6'(i * 7);
          end
          guard++;
        end
        in_a_valid = 0; in_b_valid = 0;
      end
      begin
        guard = 0;
        while (received < 300 && guard < 2000) begin
          @(negedge clk);
          if (out_valid) begin
            if (exp_q.size() == 0) check("stream_extra", out_word, 16'hxxxx);
            else check("stream_word", out_word, exp_q.pop_front());
            received++;
          end else if (received > 0) begin
            gaps++;
          end
          guard++;
        end
      end
    join
    check("stream_count", received, 300);
    check("stream_gaps",  gaps,     0);
    @(negedge clk);
    check("stream_wrap",  word_cnt, 44);
    check("stream_empty", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
